// File: rtl/mtx_compute_unit.sv
// Single-cycle, 4-slot VLIW compute tile for ternary-weight inference.
// Holds two vector registers, one ternary matrix register and a shared vector memory.
module mtx_compute_unit #(
    parameter int V     = 16,
    parameter int W     = 32,
    parameter int R     = 16,
    parameter int C     = 16,
    parameter int N_SHM = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        vliw_inst,
    input  logic [V*W-1:0]     in,
    input  logic               shm_we,
    input  logic [4:0]         write_unit_id,
    input  logic [4:0]         read_unit_id,
    output logic [V*W-1:0]     out,
    output logic [V*W-1:0]     shm_rdata,
    output logic [3:0]         st
);

    localparam logic [3:0] OpNop   = 4'd0;
    localparam logic [3:0] OpLdV0  = 4'd1;
    localparam logic [3:0] OpLdV1  = 4'd2;
    localparam logic [3:0] OpLdM0  = 4'd3;
    localparam logic [3:0] OpMvmul = 4'd4;
    localparam logic [3:0] OpPush  = 4'd5;
    localparam logic [3:0] OpZero  = 4'd6;
    localparam logic [3:0] OpPull  = 4'd7;
    localparam logic [3:0] OpRelu  = 4'd8;

    localparam logic signed [W+4:0] AccMax = {6'b000000, {(W-1){1'b1}}};
    localparam logic signed [W+4:0] AccMin = {6'b111111, {(W-1){1'b0}}};

    logic [V*W-1:0]     v0_q, v0_d;
    logic [V*W-1:0]     v1_q, v1_d;
    logic [R*C*2-1:0]   m0_q, m0_d;
    logic               sat_q, sat_d;
    logic               illegal_q, illegal_d;
    logic               push_en;
    logic [V*W-1:0]     push_data;
    logic [V*W-1:0]     mem [N_SHM];

    function automatic logic [V*W-1:0] relu(input logic [V*W-1:0] v);
        logic [V*W-1:0] r;
        r = v;
        for (int i = 0; i < V; i++) begin
            if (v[i*W+W-1]) r[i*W+:W] = '0;
        end
        return r;
    endfunction

    // Returns {saturated, result}; ternary weights reduce to add / subtract / skip.
    function automatic logic [V*W:0] mvmul(input logic [R*C*2-1:0] m, input logic [V*W-1:0] v);
        logic [V*W-1:0]    res;
        logic              sat;
        logic signed [W+4:0] acc;
        logic signed [W+4:0] ext;
        res = '0;
        sat = 1'b0;
        for (int r = 0; r < R; r++) begin
            acc = '0;
            for (int c = 0; c < C; c++) begin
                ext = {{5{v[c*W+W-1]}}, v[c*W+:W]};
                case (m[(r*C+c)*2+:2])
                    2'b01:   acc = acc + ext;
                    2'b11:   acc = acc - ext;
                    default: ;
                endcase
            end
            if (acc > AccMax) begin
                res[r*W+:W] = {1'b0, {(W-1){1'b1}}};
                sat = 1'b1;
            end else if (acc < AccMin) begin
                res[r*W+:W] = {1'b1, {(W-1){1'b0}}};
                sat = 1'b1;
            end else begin
                res[r*W+:W] = acc[W-1:0];
            end
        end
        return {sat, res};
    endfunction

    assign shm_rdata = mem[read_unit_id];

    always_comb begin
        logic [3:0]     op;
        logic [V*W:0]   mv;
        v0_d      = v0_q;
        v1_d      = v1_q;
        m0_d      = m0_q;
        sat_d     = 1'b0;
        illegal_d = 1'b0;
        push_en   = 1'b0;
        push_data = v0_q;
        mv        = '0;
        for (int s = 0; s < 4; s++) begin
            op = vliw_inst[12-4*s+:4];
            case (op)
                OpNop:   ;
                OpLdV0:  v0_d = in;
                OpLdV1:  v1_d = in;
                OpLdM0:  m0_d = in;
                OpMvmul: begin
                    mv    = mvmul(m0_d, v1_d);
                    v0_d  = mv[V*W-1:0];
                    sat_d = sat_d | mv[V*W];
                end
                OpPush: begin
                    if (shm_we) begin
                        push_en   = 1'b1;
                        push_data = v0_d;
                    end
                end
                OpZero:  v1_d = '0;
                // Reads the pre-edge memory, so a same-cycle PUSH is not visible here.
                OpPull:  v1_d = mem[read_unit_id];
                OpRelu:  v0_d = relu(v0_d);
                default: illegal_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q      <= '0;
            v1_q      <= '0;
            m0_q      <= '0;
            sat_q     <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < N_SHM; i++) mem[i] <= '0;
        end else begin
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            m0_q      <= m0_d;
            sat_q     <= sat_d;
            illegal_q <= illegal_d;
            if (push_en) mem[write_unit_id] <= push_data;
        end
    end

    assign out = v0_q;
    assign st  = {sat_q, illegal_q, (v0_q == '0), 1'b0};

endmodule

// File: tb/tb_mtx_compute_unit.sv
// Scoreboard bench for mtx_compute_unit: driver queues expected results, monitor checks them.
module tb_mtx_compute_unit;

    logic         clk;
    logic         rst;
    logic [15:0]  vliw_inst;
    logic [511:0] in_bus;
    logic         shm_we;
    logic [4:0]   write_unit_id;
    logic [4:0]   read_unit_id;
    logic [511:0] out;
    logic [511:0] shm_rdata;
    logic [3:0]   st;

    int checks = 0;
    int failures = 0;

    mtx_compute_unit dut (
        .clk           (clk),
        .rst           (rst),
        .vliw_inst     (vliw_inst),
        .in            (in_bus),
        .shm_we        (shm_we),
        .write_unit_id (write_unit_id),
        .read_unit_id  (read_unit_id),
        .out           (out),
        .shm_rdata     (shm_rdata),
        .st            (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [511:0] out;
        logic [3:0]   st;
        bit           chk_shm;
        logic [511:0] shm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (out !== mon_e.out) begin
                failures++;
                $display("FAIL %s.out got=%h want=%h", mon_e.name, out, mon_e.out);
            end
            checks++;
            if (st !== mon_e.st) begin
                failures++;
                $display("FAIL %s.st got=%b want=%b", mon_e.name, st, mon_e.st);
            end
            if (mon_e.chk_shm) begin
                checks++;
                if (shm_rdata !== mon_e.shm) begin
                    failures++;
                    $display("FAIL %s.shm got=%h want=%h", mon_e.name, shm_rdata, mon_e.shm);
                end
            end
        end
    end

    task automatic issue(input string name, input logic r, input logic [15:0] inst,
                         input logic [511:0] din, input logic we, input logic [4:0] wid,
                         input logic [4:0] rid, input logic [511:0] eo, input logic [3:0] est,
                         input bit cs, input logic [511:0] es);
        exp_t e;
        @(negedge clk);
        rst           = r;
        vliw_inst     = inst;
        in_bus        = din;
        shm_we        = we;
        write_unit_id = wid;
        read_unit_id  = rid;
        e.name    = name;
        e.out     = eo;
        e.st      = est;
        e.chk_shm = cs;
        e.shm     = es;
        sb.push_back(e);
    endtask

    function automatic logic [511:0] relu_model(input logic [511:0] v);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32+:32] = ($signed(v[i*32+:32]) < 0) ? 32'd0 : v[i*32+:32];
        return r;
    endfunction

    function automatic logic [511:0] mv_model(input logic [511:0] m, input logic [511:0] v);
        logic [511:0] r;
        longint sum;
        longint w;
        for (int i = 0; i < 16; i++) begin
            sum = 0;
            for (int c = 0; c < 16; c++) begin
                w = (m[(i*16+c)*2+:2] == 2'b01) ? 1 : (m[(i*16+c)*2+:2] == 2'b11) ? -1 : 0;
                sum += w * longint'($signed(v[c*32+:32]));
            end
            if (sum > 64'sd2147483647) sum = 64'sd2147483647;
            if (sum < -64'sd2147483648) sum = -64'sd2147483648;
            r[i*32+:32] = sum[31:0];
        end
        return r;
    endfunction

    logic [511:0] z, rnd, va, vb, vbr, v1p, mtern, vsat, mplus, vsat_out, vp, vq, mid, vmv;

    initial begin
        z = '0;
        vb = '0;
        mtern = '0;
        mid = '0;
        for (int i = 0; i < 16; i++) begin
            rnd[i*32+:32]      = $urandom;
            va[i*32+:32]       = (32'd1 << 30) + (32'(i) << 24);
            v1p[i*32+:32]      = 32'(i + 1);
            vsat[i*32+:32]     = 32'h4000_0000;
            vsat_out[i*32+:32] = 32'h7fff_ffff;
            vp[i*32+:32]       = 32'(i * 3 - 20);
            vq[i*32+:32]       = 32'(100 * i + 1);
            mid[(i*16+i)*2+:2] = 2'b01;
            for (int c = 0; c < 16; c++) begin
                mplus[(i*16+c)*2+:2] = 2'b01;
                case ((i + c) % 3)
                    0:       mtern[(i*16+c)*2+:2] = 2'b01;
                    1:       mtern[(i*16+c)*2+:2] = 2'b00;
                    default: mtern[(i*16+c)*2+:2] = 2'b11;
                endcase
            end
        end
        vb[31:0]  = -32'sd5;
        vb[63:32] = 32'sd7;
        vbr = '0;
        vbr[63:32] = 32'd7;
        vmv = mv_model(mtern, v1p);

        rst = 1'b1; vliw_inst = '0; in_bus = '0; shm_we = 1'b0;
        write_unit_id = '0; read_unit_id = '0;

        issue("rst0", 1, 16'h5555, rnd, 1, 5'd0, 5'd0, z, 4'b0010, 1, z);
        issue("rst31", 1, 16'h5555, rnd, 1, 5'd0, 5'd31, z, 4'b0010, 1, z);
        issue("ld_v0", 0, 16'h1000, va, 0, 0, 0, va, 4'b0000, 0, z);
        issue("ld_v0_b", 0, 16'h1000, vb, 0, 0, 0, vb, 4'b0000, 0, z);
        issue("relu", 0, 16'h8000, rnd, 0, 0, 0, vbr, 4'b0000, 0, z);
        issue("ld_v1", 0, 16'h2000, v1p, 0, 0, 0, vbr, 4'b0000, 0, z);
        issue("ld_m0", 0, 16'h3000, mtern, 0, 0, 0, vbr, 4'b0000, 0, z);
        issue("mvmul", 0, 16'h4000, rnd, 0, 0, 0, vmv, 4'b0000, 0, z);
        issue("ld_v1_sat", 0, 16'h2000, vsat, 0, 0, 0, vmv, 4'b0000, 0, z);
        issue("ld_m0_plus", 0, 16'h3000, mplus, 0, 0, 0, vmv, 4'b0000, 0, z);
        issue("mvmul_sat", 0, 16'h4000, rnd, 0, 0, 0, vsat_out, 4'b1000, 0, z);
        issue("nop_hold", 0, 16'h0000, rnd, 0, 0, 0, vsat_out, 4'b0000, 0, z);
        issue("ld_v0_p", 0, 16'h1000, vp, 0, 0, 0, vp, 4'b0000, 0, z);
        issue("push1", 0, 16'h5000, rnd, 1, 5'd1, 5'd1, vp, 4'b0000, 1, vp);
        issue("ld_m0_id", 0, 16'h3000, mid, 0, 0, 5'd1, vp, 4'b0000, 1, vp);
        issue("zero_v1_mv", 0, 16'h6400, rnd, 0, 0, 5'd1, z, 4'b0010, 0, z);
        issue("pull_mv", 0, 16'h7400, rnd, 0, 0, 5'd1, vp, 4'b0000, 1, vp);
        issue("push_we0", 0, 16'h1500, vq, 0, 5'd1, 5'd1, vq, 4'b0000, 1, vp);
        issue("ldv1_zero", 0, 16'h2600, vp, 0, 0, 5'd1, vq, 4'b0000, 0, z);
        issue("mv_after_zero", 0, 16'h4000, rnd, 0, 0, 5'd1, z, 4'b0010, 0, z);
        issue("ld_relu_ill", 0, 16'h18F0, vp, 0, 0, 5'd1, relu_model(vp), 4'b0100, 0, z);
        issue("ill_clear", 0, 16'h0000, rnd, 0, 0, 5'd1, relu_model(vp), 4'b0000, 0, z);
        issue("ld_v0_q", 0, 16'h1000, vq, 0, 0, 5'd1, vq, 4'b0000, 0, z);
        issue("push_pull_same", 0, 16'h5740, rnd, 1, 5'd1, 5'd1, vp, 4'b0000, 1, vq);
        issue("last_push_wins", 0, 16'h5150, va, 1, 5'd2, 5'd2, va, 4'b0000, 1, va);
        issue("rst_mid", 1, 16'h5000, rnd, 1, 5'd2, 5'd2, z, 4'b0010, 1, z);
        issue("post_rst", 0, 16'h0000, rnd, 0, 0, 5'd1, z, 4'b0010, 1, z);

        @(negedge clk);
        vliw_inst = '0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mtx_compute_unit.md
# mtx_compute_unit

A single-cycle VLIW compute tile for ternary-weight neural-network inference. It holds two vector registers (V0, V1) and one ternary matrix register (M0), and executes a 4-slot VLIW instruction every clock. It also contains a 32-entry shared vector memory, which the unit uses to exchange vectors with other tiles through PUSH/PULL.

## Interface
- V, 16: vector length (elements).
- W, 32: element width, signed two's complement.
- R, 16 / C, 16: matrix rows/cols; C must equal V, R must equal V.
- N_SHM, 32: shared-memory entries, indexed by 5-bit unit id.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- vliw_inst  in  16  four 4-bit opcodes: op1=[15:12], op2=[11:8], op3=[7:4], op4=[3:0].
- in  in  V*W (512)  load bus; vector view elem i=[i*W+:W]; matrix view entry (r,c)=[(r*C+c)*2+:2].
- shm_we  in  1  write enable; PUSH_V0 writes only when high.
- write_unit_id  in  5  shared-memory write index.
- read_unit_id  in  5  shared-memory read index.
- out  out  512  registered copy of V0.
- shm_rdata  out  512  combinational mem[read_unit_id].
- st  out  4  {sat, illegal, v0_zero, 1'b0}.

## Operation
- Opcodes: NOP=0, LD_V0=1, LD_V1=2, LD_M0=3, MVMUL=4, PUSH_V0=5, ZERO_V1=6, PULL_V1=7, VRELU=8; 9–15 are illegal.
- Ternary codes: 2'b00=ZERO, 2'b01=PLUS(+1), 2'b11=MINUS(-1); 2'b10 is treated as ZERO.
- Slots execute in order op1→op4 within one cycle. Each slot sees the register state produced by the previous slot. Only the final state is committed at the edge.
- LD_V0 / LD_V1: load the vector view of `in`.
- LD_M0: load the matrix view of `in`.
- MVMUL: V0[r] = sat32(Σc M0[r][c]·V1[c]). Accumulate at W+5 bits using add, subtract or skip only (no multipliers). Saturate to [-2^31, 2^31-1].
- PUSH_V0: if shm_we, mem[write_unit_id] ← current V0. If several PUSH slots occur, the last one wins.
- ZERO_V1: V1 ← 0.
- PULL_V1: V1 ← mem[read_unit_id], using memory contents from before the edge (read-before-write).
- VRELU: each V0[i] ← (V0[i] < 0) ? 0 : V0[i].
- Illegal opcode: behaves as NOP and sets illegal.
- st.sat: 1 if any MVMUL in this instruction saturated any element.
- st.illegal: 1 if any slot held an illegal opcode.
- Both st.sat and st.illegal are registered per instruction and are not sticky.
- st.v0_zero = (out == 0).

## Timing
- Every instruction completes in one cycle; there are no stalls and no handshake.
- V0, V1, M0, out, the shared-memory write and st.sat/st.illegal all update on the rising edge following instruction presentation.
- shm_rdata is combinational from the memory and read_unit_id.
- Reset takes priority over any instruction in the same cycle. On reset:
  - V0, V1, M0 and every shared-memory entry go to 0.
  - out = 0, st = 4'b0010.
- Reset asserted mid-sequence discards the in-flight instruction, including any pending PUSH.
- An all-NOP instruction holds every register and memory entry.
- Ids wrap naturally in 5 bits; all 32 entries are valid.

## Test plan
- **Reset.** Apply rst for 2 cycles with random inputs → out=0, st=4'b0010, shm_rdata=0 for ids 0 and 31.
- **LD_V0 + ReLU.** LD_V0 with elem i = (1<<30)+(i<<24) → out matches elem-for-elem. Then LD_V0 with elem0=-5, elem1=7 followed by VRELU → elem0=0, elem1=7.
- **MVMUL.**
  - Setup: V1 elem c = c+1. M0(r,c) = PLUS/ZERO/MINUS for (r+c)%3 = 0/1/2.
  - Check: out[r] equals the signed sum.
  - Example: row 0 = 1−3+4−6+7−9+10−12+13−15+16 = 6.
  - Expect sat=0.
- **Saturation.** V1 all 2^30, M0 all PLUS, MVMUL → every out element = 2^31−1 and st.sat=1. The following NOP → sat=0.
- **PUSH/PULL round trip.**
  - PUSH_V0 with shm_we=1, id=1 → shm_rdata (read id 1) = V0.
  - ZERO_V1 → V1 cleared.
  - PULL_V1 then MVMUL with identity M0 → out = the pushed vector.
  - PUSH_V0 with shm_we=0 → entry unchanged.
- **Slot ordering and illegal opcodes.** Instruction {LD_V1, ZERO_V1, NOP, NOP} → V1=0. Instruction {LD_V0, VRELU, 4'hF, NOP} → ReLU'd `in` is loaded and st.illegal=1. Same-edge PUSH and PULL on the same id → V1 gets the old entry.
